// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, optional hard-wired zero entry and optional write-to-read bypass.
module reg_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2
);

  localparam int unsigned NPORTS = 2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic [AW-1:0]    raddr_v [NPORTS];
  logic [WIDTH-1:0] rdata_v [NPORTS];

  // One-hot write select; out-of-range addresses and the zero entry never match.
  always_comb begin : write_decode
    wr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && rst && (waddr == AW'(i)) && !(ZERO_REG && (i == 0))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_sel[i] ? wdata : mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;

  // Reads of unmatched (out-of-range) addresses fall through to zero.
  always_comb begin : read_ports
    for (int unsigned p = 0; p < NPORTS; p++) begin
      rdata_v[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((raddr_v[p] == AW'(i)) && !(ZERO_REG && (i == 0))) begin
          rdata_v[p] = (BYPASS && wr_sel[i]) ? wdata : mem_q[i];
        end
      end
    end
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];

endmodule
